inst_mem_loader: RTL and testbench

Byte-stream loader that fills the datapath's instruction memory at run time, writing the words that instruction fetch reads. Accepts bytes over a valid/ready handshake, assembles big-endian 32-bit words, and issues one write per word at incrementing word addresses. Holds the processor in stall (`cpu_hold`) from reset until a load completes.

---
 rtl/inst_mem_loader.sv | 175 +++++++++++++++++
 tb/tb_inst_mem_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Byte-stream loader that fills instruction memory with big-endian 32-bit words and holds the CPU until done.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module inst_mem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic              chk_err
);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   written_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        idx_q;
  logic [23:0]       shift_q;
  logic [31:0]       wdata_q;
  logic              byte_ready_q;
  logic              mem_we_q;
  logic              busy_q;
  logic              done_q;
  logic              cpu_hold_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        xor_q;
  logic              chk_err_q;
`endif

  logic              hs_d;
  logic              last_d;
  logic [ADDR_W:0]   count_d;

  assign hs_d    = byte_valid & byte_ready_q;
  assign last_d  = ((written_q + (ADDR_W+1)'(1)) == count_q);
  assign count_d = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      written_q    <= '0;
      addr_q       <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      wdata_q      <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cpu_hold_q   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= '0;
      chk_err_q    <= 1'b0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            count_q    <= count_d;
            written_q  <= '0;
            addr_q     <= '0;
            idx_q      <= '0;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= '0;
            chk_err_q  <= 1'b0;
`endif
            if (count_d == '0) begin
              state_q <= DONE;
            end else begin
              state_q      <= RECV;
              byte_ready_q <= 1'b1;
            end
          end
        end
        RECV: begin
          if (hs_d) begin
            shift_q <= {shift_q[15:0], byte_in};
            idx_q   <= idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            xor_q   <= xor_q ^ byte_in;
`endif
            if (idx_q == 2'd3) begin
              wdata_q      <= {shift_q, byte_in};
              mem_we_q     <= 1'b1;
              byte_ready_q <= 1'b0;
              state_q      <= WRITE;
            end
          end
        end
        WRITE: begin
          written_q <= written_q + (ADDR_W+1)'(1);
          if (last_d) begin
            // Address is left on the final word so a full-depth load never wraps to 0.
`ifdef LOADER_CHECKSUM_EN
            byte_ready_q <= 1'b1;
            state_q      <= CHECK;
`else
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= DONE;
`endif
          end else begin
            addr_q       <= addr_q + ADDR_W'(1);
            byte_ready_q <= 1'b1;
            state_q      <= RECV;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (hs_d) begin
            chk_err_q    <= (byte_in != xor_q);
            byte_ready_q <= 1'b0;
            done_q       <= 1'b1;
            cpu_hold_q   <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= DONE;
          end
        end
`endif
        DONE: begin
          // Zero-word loads arrive here with done still low and spend one extra cycle raising it.
          if (!done_q) begin
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
            busy_q     <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cpu_hold   = cpu_hold_q;
`ifdef LOADER_CHECKSUM_EN
  assign chk_err    = chk_err_q;
`else
  assign chk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: expected writes/done times are queued at stimulus, a monitor pops them.
// Checksum scenarios run only when LOADER_CHECKSUM_EN is defined.
module tb_inst_mem_loader;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          cpu_hold;
  logic          chk_err;

  always #5 clk = ~clk;

  inst_mem_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_words  (num_words),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .cpu_hold   (cpu_hold),
    .chk_err    (chk_err)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  wr_t         exp_wr[$];
  int          exp_done[$];
  logic [31:0] tb_mem [DEPTH];
  logic [31:0] ld_words[$];
  logic [7:0]  ld_bytes[$];
  wr_t         mon_e;
  int          mon_d;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expected writes / done cycles whenever the DUT presents them.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got addr=%0d data=%h, required no write", mem_addr, mem_wdata);
        end else begin
          mon_e = exp_wr.pop_front();
          if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL write: got addr=%0d data=%h rdy=%b, required addr=%0d data=%h rdy=0",
                     mem_addr, mem_wdata, byte_ready, mon_e.addr, mon_e.data);
          end
        end
        tb_mem[mem_addr] = mem_wdata;
      end
      if (done) begin
        checks++;
        done_cnt++;
        if (exp_done.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got done at cycle %0d, required none", cyc);
        end else begin
          mon_d = exp_done.pop_front();
          if ((mon_d != 0 && cyc != mon_d) || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL done: got cycle %0d hold=%b, required cycle %0d hold=0", cyc, cpu_hold, mon_d);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, ~b, 8'h5A, b ^ 8'h3C};
  endfunction

  // Called at a negedge; returns at a negedge after the last byte was accepted.
  task automatic send(input bit gaps);
    int   idx;
    int   guard;
    bit   ph;
    logic r;
    idx = 0; guard = 0; ph = 1'b0;
    while (idx < ld_bytes.size() && guard < 6000) begin
      if (gaps && ph) begin
        byte_valid = 1'b0;
      end else begin
        byte_valid = 1'b1;
        byte_in    = ld_bytes[idx];
      end
      r = byte_ready;
      @(posedge clk);
      if (byte_valid && r) idx++;
      ph = !ph;
      guard++;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    chk("send_complete", 64'(idx), 64'(ld_bytes.size()));
  endtask

  task automatic run_load(input int n, input bit gaps, input bit full, input bit bad_cs);
    int         nsat;
    int         c0;
    int         lat;
    logic [7:0] x;
    wr_t        w;
    nsat = (n > int'(DEPTH)) ? int'(DEPTH) : n;
    ld_bytes.delete();
    x = '0;
    for (int i = 0; i < ld_words.size(); i++) begin
      w.addr = i[AW-1:0];
      w.data = ld_words[i];
      exp_wr.push_back(w);
      for (int j = 3; j >= 0; j--) begin
        ld_bytes.push_back(ld_words[i][8*j +: 8]);
        x = x ^ ld_words[i][8*j +: 8];
      end
    end
    if (bad_cs) x = x ^ 8'h01;
    lat = 5 * nsat;
`ifdef LOADER_CHECKSUM_EN
    if (nsat > 0) begin
      ld_bytes.push_back(x);
      lat = lat + 1;
    end
`endif
    if (nsat == 0) lat = 1;
    c0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    num_words = n[AW:0];
    @(negedge clk);
    start = 1'b0;
    exp_done.push_back(full ? cyc + lat : 0);
    chk("hold_during_load", 64'(cpu_hold), 64'd1);
    send(gaps);
    for (int k = 0; k < 3000 && done_cnt == c0; k++) @(posedge clk);
    @(negedge clk);
    chk("done_seen", 64'(done_cnt - c0), 64'd1);
    chk("hold_after_load", 64'(cpu_hold), 64'd0);
    chk("busy_after_load", 64'(busy), 64'd0);
    chk("writes_drained", 64'(exp_wr.size()), 64'd0);
  endtask

  initial begin
    int c0;
    wr_t w;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_hold", 64'(cpu_hold), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_outputs", {59'd0, byte_ready, mem_we, done, chk_err, 1'b0}, 64'd0);
    chk("rst_addr_data", {mem_addr, mem_wdata}, 64'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_hold", 64'(cpu_hold), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_no_done", 64'(done_cnt), 64'd0);

    // Two words, back-to-back bytes
    ld_words = '{32'h20080005, 32'hAC090004};
    run_load(2, 1'b0, 1'b1, 1'b0);
    chk("chk_err_good", 64'(chk_err), 64'd0);

    // Same load with byte_valid toggling every other cycle
    run_load(2, 1'b1, 1'b0, 1'b0);

    // Zero-word load
    ld_words.delete();
    run_load(0, 1'b0, 1'b1, 1'b0);

    // Over-depth request saturates to DEPTH words
    ld_words.delete();
    for (int i = 0; i < int'(DEPTH); i++) ld_words.push_back(pat(i));
    run_load(int'(DEPTH) + 5, 1'b0, 1'b1, 1'b0);
    chk("sat_last_addr", 64'(mem_addr), 64'(DEPTH - 1));

    // Reset after 6 bytes of a 3-word load: first word already written, partial word lost
    w.addr = '0;
    w.data = 32'hDEADBEEF;
    exp_wr.push_back(w);
    ld_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE};
    c0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    num_words = 9'd3;
    @(negedge clk);
    start = 1'b0;
    send(1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_hold", 64'(cpu_hold), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(byte_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_no_done", 64'(done_cnt - c0), 64'd0);
    chk("midrst_first_written", 64'(exp_wr.size()), 64'd0);
    ld_words = '{32'h12345678};
    run_load(1, 1'b0, 1'b1, 1'b0);
    chk("mem0_rewritten", 64'(tb_mem[0]), 64'h12345678);
    chk("mem1_untouched", 64'(tb_mem[1]), 64'(pat(1)));
    chk("mem2_untouched", 64'(tb_mem[2]), 64'(pat(2)));

`ifdef LOADER_CHECKSUM_EN
    ld_words = '{32'h01020304};
    run_load(1, 1'b0, 1'b1, 1'b0);
    chk("cs_ok", 64'(chk_err), 64'd0);
    run_load(1, 1'b0, 1'b1, 1'b1);
    chk("cs_bad", 64'(chk_err), 64'd1);
    repeat (5) @(negedge clk);
    chk("cs_bad_held", 64'(chk_err), 64'd1);
    ld_words.delete();
    run_load(0, 1'b0, 1'b1, 1'b0);
    chk("cs_cleared_by_start", 64'(chk_err), 64'd0);
`endif

    chk("done_queue_drained", 64'(exp_done.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
